// File: rtl/ipd_secuenciador.sv
// Sample-rate sequencer for the servo IPD loop: periodic tick, ADC handshake,
// datapath enable, latency wait and clamped capture of the control effort.
module ipd_secuenciador #(
    parameter int cant_bits    = 16,
    parameter int DIV_MUESTREO = 50000,
    parameter int LAT_IPD      = 2,
    parameter int TIMEOUT_ADC  = 1000,
    parameter int U_MAX        = 2**(cant_bits-1)-1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [cant_bits-1:0] adc_dato,
    input  logic                 adc_valid,
    input  logic [cant_bits-1:0] ref_in,
    input  logic [cant_bits-1:0] salida_in,
    input  logic                 clr_err,
    output logic                 adc_req,
    output logic [cant_bits-1:0] pot_out,
    output logic [cant_bits-1:0] ref_out,
    output logic                 en_ipd,
    output logic [cant_bits-1:0] u_out,
    output logic                 u_valid,
    output logic                 busy,
    output logic                 overrun,
    output logic                 timeout_err
);

    localparam int CNT_W = (DIV_MUESTREO > 1) ? $clog2(DIV_MUESTREO) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_ADC + 1);
    localparam int LAT_W = $clog2(LAT_IPD + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_MUESTREO - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_ADC - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LAT_IPD - 1);

    localparam logic signed [cant_bits-1:0] U_POS = cant_bits'(U_MAX);
    localparam logic signed [cant_bits-1:0] U_NEG = cant_bits'(-U_MAX);

    typedef enum logic [2:0] {IDLE, REQ, EN, ESPERA, LATCH} estado_t;

    estado_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic signed [cant_bits-1:0] pot_q, pot_d;
    logic signed [cant_bits-1:0] ref_q, ref_d;
    logic signed [cant_bits-1:0] u_q, u_d;
    logic adc_req_q, adc_req_d;
    logic en_ipd_q, en_ipd_d;
    logic u_valid_q, u_valid_d;
    logic busy_q, busy_d;
    logic overrun_q, overrun_d;
    logic timeout_q, timeout_d;
    logic tick;
    logic set_timeout;
    logic set_overrun;

    // Symmetric saturation; the most negative code also lands on -U_MAX.
    function automatic logic signed [cant_bits-1:0] clamp_u(input logic signed [cant_bits-1:0] x);
        if (x > U_POS)
            clamp_u = U_POS;
        else if (x < U_NEG)
            clamp_u = U_NEG;
        else
            clamp_u = x;
    endfunction

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        to_cnt_d    = to_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        pot_d       = pot_q;
        ref_d       = ref_q;
        u_d         = u_q;
        set_timeout = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d  = REQ;
                    to_cnt_d = '0;
                end
            end
            REQ: begin
                to_cnt_d = to_cnt_q + 1'b1;
                // A valid on the last allowed cycle still counts as an answer.
                if (adc_valid) begin
                    pot_d   = $signed(adc_dato);
                    ref_d   = $signed(ref_in);
                    state_d = EN;
                end else if (to_cnt_q == TO_LAST) begin
                    set_timeout = 1'b1;
                    state_d     = IDLE;
                end
            end
            EN: begin
                state_d   = ESPERA;
                lat_cnt_d = '0;
            end
            ESPERA: begin
                lat_cnt_d = lat_cnt_q + 1'b1;
                if (lat_cnt_q == LAT_LAST) begin
                    u_d     = clamp_u($signed(salida_in));
                    state_d = LATCH;
                end
            end
            LATCH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A tick outside IDLE is flagged and otherwise discarded.
        set_overrun = tick && (state_q != IDLE);
        overrun_d   = set_overrun | (overrun_q & ~clr_err);
        timeout_d   = set_timeout | (timeout_q & ~clr_err);

        adc_req_d = (state_d == REQ);
        en_ipd_d  = (state_d == EN);
        u_valid_d = (state_d == LATCH);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            to_cnt_q  <= '0;
            lat_cnt_q <= '0;
            pot_q     <= '0;
            ref_q     <= '0;
            u_q       <= '0;
            adc_req_q <= 1'b0;
            en_ipd_q  <= 1'b0;
            u_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            to_cnt_q  <= to_cnt_d;
            lat_cnt_q <= lat_cnt_d;
            pot_q     <= pot_d;
            ref_q     <= ref_d;
            u_q       <= u_d;
            adc_req_q <= adc_req_d;
            en_ipd_q  <= en_ipd_d;
            u_valid_q <= u_valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign adc_req     = adc_req_q;
    assign pot_out     = pot_q;
    assign ref_out     = ref_q;
    assign en_ipd      = en_ipd_q;
    assign u_out       = u_q;
    assign u_valid     = u_valid_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_ipd_secuenciador.sv
// Bench for ipd_secuenciador: directed scenarios with randomized data, checked
// against a timing/clamp reference model; a second instance with a long ADC timeout covers overrun.
module tb_ipd_secuenciador;

    localparam int W    = 16;
    localparam int DIV  = 20;
    localparam int LAT  = 2;
    localparam int TO   = 8;
    localparam int UMAX = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    logic [W-1:0] adc_dato = '0;
    logic [W-1:0] ref_in = '0;
    logic [W-1:0] salida_in = '0;
    logic adc_valid = 1'b0;
    logic clr_err = 1'b0;

    logic adc_req1, en1, uv1, busy1, ovr1, to1;
    logic [W-1:0] pot1, ref1, u1;
    logic adc_req2, en2, uv2, busy2, ovr2, to2;
    logic [W-1:0] pot2, ref2, u2;

    logic sel = 1'b0;
    logic m_req, m_en, m_uv, m_busy, m_ovr, m_to;
    logic [W-1:0] m_pot, m_ref, m_u;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int en_cnt = 0;
    int uv_cnt = 0;
    logic signed [31:0] last_u = 0;

    ipd_secuenciador #(.cant_bits(W), .DIV_MUESTREO(DIV), .LAT_IPD(LAT),
                       .TIMEOUT_ADC(TO), .U_MAX(UMAX)) dut (
        .clk(clk), .rst(rst), .adc_dato(adc_dato), .adc_valid(adc_valid),
        .ref_in(ref_in), .salida_in(salida_in), .clr_err(clr_err),
        .adc_req(adc_req1), .pot_out(pot1), .ref_out(ref1), .en_ipd(en1),
        .u_out(u1), .u_valid(uv1), .busy(busy1), .overrun(ovr1), .timeout_err(to1));

    ipd_secuenciador #(.cant_bits(W), .DIV_MUESTREO(DIV), .LAT_IPD(LAT),
                       .TIMEOUT_ADC(32), .U_MAX(UMAX)) dut_ovr (
        .clk(clk), .rst(rst2), .adc_dato(adc_dato), .adc_valid(adc_valid),
        .ref_in(ref_in), .salida_in(salida_in), .clr_err(clr_err),
        .adc_req(adc_req2), .pot_out(pot2), .ref_out(ref2), .en_ipd(en2),
        .u_out(u2), .u_valid(uv2), .busy(busy2), .overrun(ovr2), .timeout_err(to2));

    assign m_req  = sel ? adc_req2 : adc_req1;
    assign m_en   = sel ? en2 : en1;
    assign m_uv   = sel ? uv2 : uv1;
    assign m_busy = sel ? busy2 : busy1;
    assign m_ovr  = sel ? ovr2 : ovr1;
    assign m_to   = sel ? to2 : to1;
    assign m_pot  = sel ? pot2 : pot1;
    assign m_ref  = sel ? ref2 : ref1;
    assign m_u    = sel ? u2 : u1;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_en === 1'b1) en_cnt <= en_cnt + 1;
        if (m_uv === 1'b1) uv_cnt <= uv_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp_m(input int x);
        if (x > UMAX) return UMAX;
        if (x < -UMAX) return -UMAX;
        return x;
    endfunction

    task automatic wait_req(output int t);
        t = -1;
        for (int i = 0; i < 45; i++) begin
            step();
            if (m_req === 1'b1) begin
                t = cyc;
                break;
            end
        end
        chk("req_seen", (t >= 0), 1);
    endtask

    // One full sample: request, answer after d cycles, check enable, latency and clamp.
    task automatic do_seq(input int d, input logic signed [W-1:0] dato, input logic signed [W-1:0] rf,
                          input logic signed [W-1:0] sal, input int tr, output int t);
        int e0, u0;
        wait_req(t);
        chk("req_phase", (t - tr) % DIV, 0);
        e0 = en_cnt;
        u0 = uv_cnt;
        repeat (d) step();
        chk("req_hold", m_req, 1);
        adc_valid = 1'b1; adc_dato = dato; ref_in = rf;
        step();
        adc_valid = 1'b0; adc_dato = W'($urandom); ref_in = W'($urandom); salida_in = W'($urandom);
        chk("en_pulse", m_en, 1);
        chk("req_drop", m_req, 0);
        chk("busy_en", m_busy, 1);
        chk("pot", $signed(m_pot), dato);
        chk("ref", $signed(m_ref), rf);
        step();
        salida_in = W'($urandom);
        chk("en_single", m_en, 0);
        step();
        salida_in = sal;
        step();
        salida_in = W'($urandom);
        last_u = clamp_m(int'(sal));
        chk("u_valid", m_uv, 1);
        chk("u_out", $signed(m_u), last_u);
        chk("pot_stable", $signed(m_pot), dato);
        chk("ref_stable", $signed(m_ref), rf);
        step();
        chk("u_valid_end", m_uv, 0);
        chk("busy_idle", m_busy, 0);
        chk("en_count", en_cnt - e0, 1);
        chk("uv_count", uv_cnt - u0, 1);
    endtask

    initial begin
        int t, t2, t3, t_rst, e0, u0;

        // reset state
        repeat (2) step();
        chk("rst_req", adc_req1, 0);
        chk("rst_en", en1, 0);
        chk("rst_uv", uv1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_ovr", ovr1, 0);
        chk("rst_to", to1, 0);
        chk("rst_u", $signed(u1), 0);
        chk("rst_pot", $signed(pot1), 0);
        rst = 1'b0;
        t_rst = cyc;

        // spurious valid while idle
        adc_valid = 1'b1; adc_dato = 16'h1234; ref_in = 16'h0abc;
        repeat (3) step();
        adc_valid = 1'b0;
        chk("spur_req", adc_req1, 0);
        chk("spur_en", en_cnt, 0);
        chk("spur_pot", $signed(pot1), 0);
        chk("spur_busy", busy1, 0);

        // nominal and clamp cases
        do_seq(2, 16'sd120, 16'sd300, 16'sd450, t_rst, t);
        chk("first_req", t - t_rst, DIV);
        chk("nom_ovr", ovr1, 0);
        chk("nom_to", to1, 0);
        do_seq(1, -16'sd5, 16'sd7, 16'sd5000, t_rst, t);
        do_seq(0, 16'sd9, -16'sd9, 16'sh8000, t_rst, t);
        do_seq(4, 16'sd1, 16'sd2, -16'sd999, t_rst, t);

        for (int k = 0; k < 4; k++) begin
            logic signed [W-1:0] sal;
            sal = ($urandom % 2 == 0) ? W'(int'($urandom_range(0, 2000)) - 1000) : W'($urandom);
            do_seq(int'($urandom_range(0, 6)), W'($urandom), W'($urandom), sal, t_rst, t);
        end

        // ADC never answers
        wait_req(t);
        e0 = en_cnt;
        u0 = uv_cnt;
        for (int i = 1; i < TO; i++) begin
            step();
            chk("to_req_hold", adc_req1, 1);
        end
        step();
        chk("to_req_drop", adc_req1, 0);
        chk("to_flag", to1, 1);
        chk("to_busy", busy1, 0);
        chk("to_en", en_cnt - e0, 0);
        chk("to_uv", uv_cnt - u0, 0);
        chk("to_u_kept", $signed(u1), last_u);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("to_clr", to1, 0);

        // valid on the timeout limit wins
        do_seq(TO - 1, 16'sd42, 16'sd43, 16'sd44, t_rst, t);
        chk("coinc_to", to1, 0);

        // reset during the latency wait
        wait_req(t);
        step();
        adc_valid = 1'b1; adc_dato = 16'sd77; ref_in = 16'sd78;
        step();
        adc_valid = 1'b0;
        step();
        rst = 1'b1;
        u0 = uv_cnt;
        step();
        rst = 1'b0;
        t_rst = cyc;
        chk("mid_req", adc_req1, 0);
        chk("mid_en", en1, 0);
        chk("mid_busy", busy1, 0);
        chk("mid_u", $signed(u1), 0);
        chk("mid_pot", $signed(pot1), 0);
        chk("mid_ref", $signed(ref1), 0);
        repeat (4) step();
        chk("mid_no_uv", uv_cnt - u0, 0);
        last_u = 0;
        do_seq(3, 16'sd11, 16'sd12, 16'sd13, t_rst, t);
        chk("mid_restart", t - t_rst, DIV);

        // overrun on the long-timeout instance
        sel = 1'b1;
        step();
        rst2 = 1'b0;
        t_rst = cyc;
        do_seq(19, 16'sd55, -16'sd66, 16'sd300, t_rst, t);
        chk("ovr_req", ovr2, 1);
        chk("ovr_no_to", to2, 0);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("ovr_clr", ovr2, 0);
        do_seq(4, 16'sd5, 16'sd6, -16'sd2000, t_rst, t2);
        chk("ovr_dropped", t2 - t, 2 * DIV);
        chk("ovr_quiet", ovr2, 0);
        do_seq(15, 16'sd8, 16'sd9, 16'sd10, t_rst, t3);
        chk("ovr_latch", ovr2, 1);
        chk("ovr_latch_noreq", adc_req2, 0);
        wait_req(t);
        chk("ovr_next", t - t3, 2 * DIV);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ipd_secuenciador.md
Name: ipd_secuenciador

Overview:
Sample-rate sequencer for the servo IPD control loop. It generates the loop sampling tick and requests a position sample from the ADC front end. It freezes a coherent Pot/Ref pair, fires the one-cycle enable into the IPD + truncation datapath, waits the datapath latency, then clamps and registers the truncated control effort for the PWM stage. Timing faults (sample overrun, ADC timeout) are flagged as sticky errors.

Parameters:
cant_bits, 16, datapath width (signed) of Pot, Ref and control effort
DIV_MUESTREO, 50000, clk cycles per control sample period (>= LAT_IPD+4)
LAT_IPD, 2, clk cycles from en_ipd pulse to valid salida_in (>= 1)
TIMEOUT_ADC, 1000, max clk cycles waiting for adc_valid
U_MAX, 2**(cant_bits-1)-1, symmetric clamp limit for u_out (positive)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
adc_dato  in  cant_bits  signed position sample from ADC front end
adc_valid  in  1  adc_dato valid; accepted only while adc_req=1
ref_in  in  cant_bits  signed setpoint, sampled alongside adc_dato
salida_in  in  cant_bits  signed truncated effort returned by the IPD datapath
clr_err  in  1  clears overrun and timeout_err
adc_req  out  1  sample request to ADC, held until accepted or timeout
pot_out  out  cant_bits  frozen position to datapath Pot
ref_out  out  cant_bits  frozen setpoint to datapath Ref
en_ipd  out  1  one-cycle datapath enable (drives Rx_En/en)
u_out  out  cant_bits  clamped control effort, held between updates
u_valid  out  1  one-cycle pulse when u_out is updated
busy  out  1  high in any state other than IDLE
overrun  out  1  sticky: tick arrived while not IDLE
timeout_err  out  1  sticky: ADC did not answer within TIMEOUT_ADC

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; tick counter 0; all outputs 0. Reset mid-sequence aborts it with no en_ipd or u_valid pulse.
- Tick counter: free-running 0..DIV_MUESTREO-1 and wraps. tick=1 in the cycle the counter equals DIV_MUESTREO-1. The counter is never stalled by the FSM.
- FSM states: IDLE, REQ, EN, ESPERA, LATCH. All outputs are registered.
- IDLE: on tick, go to REQ. adc_req=1 from the next cycle. Timeout counter cleared.
- REQ: adc_req held high and the timeout counter increments each cycle.
  - adc_valid=1 at edge v: pot_out<=adc_dato and ref_out<=ref_in at the same edge. adc_req=0 and en_ipd=1 during cycle v+1 (state EN).
  - Timeout counter reaches TIMEOUT_ADC with no valid: adc_req<=0, timeout_err<=1, return to IDLE. No en_ipd pulse; u_out unchanged.
  - If adc_valid and the timeout limit coincide, the valid wins.
- EN: lasts exactly one cycle (en_ipd=1), then ESPERA with the wait counter cleared.
- ESPERA: counts LAT_IPD cycles, then LATCH.
- LATCH: u_out<=clamp(salida_in) and u_valid=1 for exactly one cycle, then IDLE.
  - Net latency: u_valid is high in cycle v+2+LAT_IPD.
- Clamp: salida_in > U_MAX gives U_MAX; salida_in < -U_MAX gives -U_MAX; otherwise pass-through. -2**(cant_bits-1) maps to -U_MAX. Comparisons are signed.
- pot_out and ref_out change only on ADC acceptance. They are stable from EN through LATCH.
- Overrun: tick while state != IDLE sets overrun<=1, and that tick is dropped. The current sequence completes normally. A tick in the same cycle as LATCH→IDLE also counts as overrun.
- clr_err=1 clears both sticky flags. If a set condition occurs in the same cycle, the set wins.
- adc_valid outside REQ is ignored.

Test Plan:
- Bench params DIV_MUESTREO=20, LAT_IPD=2, TIMEOUT_ADC=8, cant_bits=16, U_MAX=1000.
- Nominal: ADC answers 3 cycles after adc_req with adc_dato=120, ref_in=300; salida_in=450 → pot_out=120, ref_out=300, single en_ipd pulse, u_out=450 with u_valid exactly 4 cycles after valid, busy low afterwards, no flags.
- Clamp: salida_in=5000 → u_out=1000; salida_in=-32768 → u_out=-1000; salida_in=-999 → u_out=-999.
- Timeout: adc_valid never asserted → adc_req high 8 cycles then low, timeout_err=1, no en_ipd or u_valid, u_out keeps previous value. clr_err pulse → timeout_err=0.
- Overrun: ADC delayed 19 cycles so the next tick lands in REQ → overrun=1, that tick produces no second request, sequence completes; next tick sequences normally.
- Reset mid-ESPERA: rst=1 for 1 cycle → all outputs 0 next cycle, no u_valid; the next sequence starts 20 cycles after reset release.
- Spurious adc_valid in IDLE and a valid coincident with the timeout limit → former ignored; latter accepted with timeout_err=0.
